// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, RUN/HALT control and the IF/ID pipeline register.
// The instruction memory read is combinational, so each fetched word lands in IF/ID one edge later.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] PROG_BYTES = 64'd88,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] inst_address,
  input  logic [63:0] instruction,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instruction,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // Two-state control; halted mirrors the state register and doubles as its debug view.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [63:0] branch_aligned;

  logic unused_bits;
  assign unused_bits = ^{instruction[63:32], branch_target[1:0]};

  assign branch_aligned = {branch_target[63:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_inst_d   = ifid_inst_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    if (branch_taken) begin
      // A redirect flushes the slot being fetched and overrides any stall.
      pc_d         = branch_aligned;
      ifid_pc_d    = pc_q;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
      state_d      = (branch_aligned < PROG_BYTES) ? ST_RUN : ST_HALT;
    end else if (state_q == ST_HALT) begin
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (pc_q < PROG_BYTES) begin
      pc_d          = pc_q + 64'd4;
      ifid_pc_d     = pc_q;
      ifid_inst_d   = instruction[31:0];
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      state_d      = ST_HALT;
      ifid_pc_d    = pc_q;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= (RESET_PC < PROG_BYTES) ? ST_RUN : ST_HALT;
      halted_q      <= !(RESET_PC < PROG_BYTES);
      pc_q          <= RESET_PC;
      ifid_pc_q     <= 64'd0;
      ifid_inst_q   <= NOP_INST;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign inst_address     = pc_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_instruction = ifid_inst_q;
  assign ifid_valid       = ifid_valid_q;
  assign halted           = halted_q;
  assign fetch_count      = fetch_count_q;

endmodule
